// File: rtl/axis_argmax.sv
// Argmax tail stage: streams float32 elements, emits the index of the largest one.
// Optional ARGMAX_EMIT_VALUE_EN appends the winning element's raw bits as a second word.
module axis_argmax #(
    parameter int N_ELEMS = 4,
    parameter int IDX_W   = 2
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [31:0] INPUT_AXIS_TDATA,
    input  logic        INPUT_AXIS_TLAST,
    input  logic        INPUT_AXIS_TVALID,
    output logic        INPUT_AXIS_TREADY,
    output logic [31:0] OUTPUT_AXIS_TDATA,
    output logic        OUTPUT_AXIS_TLAST,
    output logic        OUTPUT_AXIS_TVALID,
    input  logic        OUTPUT_AXIS_TREADY,
    output logic        len_err
);

    typedef enum logic [1:0] {
        S_RECV = 2'd0,
        S_IDX  = 2'd1,
        S_VAL  = 2'd2
    } state_t;

    // Maps float32 bits to an unsigned key whose ordering matches the float ordering.
    function automatic logic [31:0] order_key(input logic [31:0] bits);
        order_key = bits[31] ? ~bits : (bits ^ 32'h8000_0000);
    endfunction

    state_t            state_r;
    logic [IDX_W-1:0]  cnt_r;
    logic [31:0]       max_key_r;
    logic [IDX_W-1:0]  max_idx_r;
    logic              ready_r;
    logic [31:0]       out_data_r;
    logic              out_last_r;
    logic              out_valid_r;
    logic              len_err_r;
`ifdef ARGMAX_EMIT_VALUE_EN
    logic [31:0]       max_val_r;
    logic [31:0]       win_val_s;
`endif

    logic              in_take_s;
    logic              last_cnt_s;
    logic              eov_s;
    logic [31:0]       cand_key_s;
    logic [31:0]       win_key_s;
    logic [IDX_W-1:0]  win_idx_s;

    assign INPUT_AXIS_TREADY  = ready_r & ~areset;
    assign OUTPUT_AXIS_TDATA  = out_data_r;
    assign OUTPUT_AXIS_TLAST  = out_last_r;
    assign OUTPUT_AXIS_TVALID = out_valid_r;
    assign len_err            = len_err_r;

    // Running winner including the word currently on the input; first element always loads.
    always_comb begin
        in_take_s  = INPUT_AXIS_TVALID & INPUT_AXIS_TREADY;
        last_cnt_s = (cnt_r == IDX_W'(N_ELEMS - 1));
        eov_s      = in_take_s & (INPUT_AXIS_TLAST | last_cnt_s);
        cand_key_s = order_key(INPUT_AXIS_TDATA);
        win_key_s  = max_key_r;
        win_idx_s  = max_idx_r;
`ifdef ARGMAX_EMIT_VALUE_EN
        win_val_s  = max_val_r;
`endif
        if ((cnt_r == {IDX_W{1'b0}}) || (cand_key_s > max_key_r)) begin
            win_key_s = cand_key_s;
            win_idx_s = cnt_r;
`ifdef ARGMAX_EMIT_VALUE_EN
            win_val_s = INPUT_AXIS_TDATA;
`endif
        end else begin
            win_key_s = max_key_r;
            win_idx_s = max_idx_r;
        end
    end

    // Receive/send FSM with registered stream outputs and length-error pulse.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r     <= S_RECV;
            cnt_r       <= {IDX_W{1'b0}};
            max_key_r   <= 32'h0000_0000;
            max_idx_r   <= {IDX_W{1'b0}};
            ready_r     <= 1'b1;
            out_data_r  <= 32'h0000_0000;
            out_last_r  <= 1'b0;
            out_valid_r <= 1'b0;
            len_err_r   <= 1'b0;
`ifdef ARGMAX_EMIT_VALUE_EN
            max_val_r   <= 32'h0000_0000;
`endif
        end else begin
            len_err_r <= 1'b0;
            case (state_r)
                S_RECV: begin
                    if (in_take_s) begin
                        max_key_r <= win_key_s;
                        max_idx_r <= win_idx_s;
`ifdef ARGMAX_EMIT_VALUE_EN
                        max_val_r <= win_val_s;
`endif
                        if (eov_s) begin
                            cnt_r       <= {IDX_W{1'b0}};
                            ready_r     <= 1'b0;
                            out_valid_r <= 1'b1;
                            out_data_r  <= {{(32 - IDX_W){1'b0}}, win_idx_s};
`ifdef ARGMAX_EMIT_VALUE_EN
                            out_last_r  <= 1'b0;
`else
                            out_last_r  <= 1'b1;
`endif
                            // Mismatch covers both early TLAST and missing TLAST.
                            len_err_r   <= INPUT_AXIS_TLAST ^ last_cnt_s;
                            state_r     <= S_IDX;
                        end else begin
                            cnt_r <= cnt_r + IDX_W'(1);
                        end
                    end
                end
                S_IDX: begin
                    if (OUTPUT_AXIS_TREADY) begin
`ifdef ARGMAX_EMIT_VALUE_EN
                        out_data_r  <= max_val_r;
                        out_last_r  <= 1'b1;
                        state_r     <= S_VAL;
`else
                        out_valid_r <= 1'b0;
                        out_data_r  <= 32'h0000_0000;
                        out_last_r  <= 1'b0;
                        ready_r     <= 1'b1;
                        state_r     <= S_RECV;
`endif
                    end
                end
                S_VAL: begin
                    if (OUTPUT_AXIS_TREADY) begin
                        out_valid_r <= 1'b0;
                        out_data_r  <= 32'h0000_0000;
                        out_last_r  <= 1'b0;
                        ready_r     <= 1'b1;
                        state_r     <= S_RECV;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    out_data_r  <= 32'h0000_0000;
                    out_last_r  <= 1'b0;
                    ready_r     <= 1'b1;
                    cnt_r       <= {IDX_W{1'b0}};
                    state_r     <= S_RECV;
                end
            endcase
        end
    end

endmodule
